// File: rtl/mult4_seq_ctrl.sv
// Sequencer for an OP_W x OP_W unsigned multiply built on one shared 4x4 multiplier.
// Walks all nibble pairs, shift-accumulates the partial products, then holds the result.
module mult4_seq_ctrl #(
    parameter int OP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic [3:0]        mul_m,
    output logic [3:0]        mul_q,
    input  logic [7:0]        mul_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*OP_W-1:0] out_prod,
    output logic              busy
);

    localparam int N     = OP_W / 4;
    localparam int STEPS = N * N;
    localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int PW    = 2 * OP_W;

    localparam logic [KW-1:0] N_K  = KW'(N);
    localparam logic [KW-1:0] LAST = KW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [OP_W-1:0] a_q, a_d;
    logic [OP_W-1:0] b_q, b_d;

    logic [KW-1:0]   i_idx;
    logic [KW-1:0]   j_idx;
    logic [KW+1:0]   sh_i;
    logic [KW+1:0]   sh_j;
    logic [KW+2:0]   sh_p;
    logic [PW-1:0]   pp;

    // k walks a-nibbles fastest: i = k mod N, j = k div N
    assign i_idx = k_q % N_K;
    assign j_idx = k_q / N_K;
    assign sh_i  = {i_idx, 2'b00};
    assign sh_j  = {j_idx, 2'b00};
    assign sh_p  = {({1'b0, i_idx} + {1'b0, j_idx}), 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        mul_m   = 4'h0;
        mul_q   = 4'h0;
        pp      = '0;
        pp[7:0] = mul_p;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                mul_m = 4'(a_q >> sh_i);
                mul_q = 4'(b_q >> sh_j);
                acc_d = acc_q + (pp << sh_p);
                if (k_q == LAST) begin
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result is gated so an aborted partial sum is never visible
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_prod  = (state_q == DONE) ? acc_q : '0;

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// Bench for mult4_seq_ctrl: directed vectors and corner sequences on OP_W=8,
// scoreboarded random traffic on OP_W=8 and OP_W=12.
module tb_mult4_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        v8, rdy8, ov8, or8, busy8;
    logic [7:0]  a8, b8, p8;
    logic [3:0]  m8, qn8;
    logic [15:0] prod8;

    logic        v12, rdy12, ov12, or12, busy12;
    logic [11:0] a12, b12;
    logic [7:0]  p12;
    logic [3:0]  m12, qn12;
    logic [23:0] prod12;

    // Models of the shared combinational 4x4 multiplier
    assign p8  = {4'h0, m8} * {4'h0, qn8};
    assign p12 = {4'h0, m12} * {4'h0, qn12};

    mult4_seq_ctrl #(.OP_W(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(v8), .in_ready(rdy8),
        .in_a(a8), .in_b(b8),
        .mul_m(m8), .mul_q(qn8), .mul_p(p8),
        .out_valid(ov8), .out_ready(or8),
        .out_prod(prod8), .busy(busy8)
    );

    mult4_seq_ctrl #(.OP_W(12)) dut12 (
        .clk(clk), .rst(rst),
        .in_valid(v12), .in_ready(rdy12),
        .in_a(a12), .in_b(b12),
        .mul_m(m12), .mul_q(qn12), .mul_p(p12),
        .out_valid(ov12), .out_ready(or12),
        .out_prod(prod12), .busy(busy12)
    );

    int total = 0;
    int passed = 0;

    logic [15:0] sb8[$];
    logic [23:0] sb12[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp);
        int n = 0;
        @(negedge clk);
        while (!rdy8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy8) chk("issue8_ready_timeout", 32'd0, 32'd1);
        v8 = 1'b1;
        a8 = a;
        b8 = b;
        @(posedge clk);
        sb8.push_back(exp);
        @(negedge clk);
        v8 = 1'b0;
    endtask

    task automatic collect8(input int stall, output int lat);
        logic [15:0] exp;
        lat = 1;
        while (!ov8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!ov8) begin
            chk("collect8_timeout", 32'd0, 32'd1);
            return;
        end
        repeat (stall) @(negedge clk);
        or8 = 1'b1;
        if (sb8.size() == 0) begin
            chk("sb8_empty", 32'd0, 32'd1);
        end else begin
            exp = sb8.pop_front();
            chk("prod8", {16'h0, prod8}, {16'h0, exp});
        end
        @(posedge clk);
        @(negedge clk);
        or8 = 1'b0;
    endtask

    task automatic issue12(input logic [11:0] a, input logic [11:0] b);
        int n = 0;
        @(negedge clk);
        while (!rdy12 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy12) chk("issue12_ready_timeout", 32'd0, 32'd1);
        v12 = 1'b1;
        a12 = a;
        b12 = b;
        @(posedge clk);
        sb12.push_back(24'(a) * 24'(b));
        @(negedge clk);
        v12 = 1'b0;
    endtask

    task automatic collect12(input int stall);
        logic [23:0] exp;
        int n = 0;
        while (!ov12 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ov12) begin
            chk("collect12_timeout", 32'd0, 32'd1);
            return;
        end
        repeat (stall) @(negedge clk);
        or12 = 1'b1;
        if (sb12.size() == 0) begin
            chk("sb12_empty", 32'd0, 32'd1);
        end else begin
            exp = sb12.pop_front();
            chk("prod12", {8'h0, prod12}, {8'h0, exp});
        end
        @(posedge clk);
        @(negedge clk);
        or12 = 1'b0;
    endtask

    initial begin
        int lat;
        int n;
        logic [3:0] exp_m[4];
        logic [3:0] exp_q[4];

        vecs[0] = '{8'hFF, 8'hFF, 16'hFE01, 5};
        vecs[1] = '{8'h21, 8'h43, 16'h08A3, 5};
        vecs[2] = '{8'h12, 8'h34, 16'h03A8, 5};
        vecs[3] = '{8'h0A, 8'h0B, 16'h006E, 5};
        vecs[4] = '{8'h00, 8'hFF, 16'h0000, 5};
        vecs[5] = '{8'h01, 8'h01, 16'h0001, 5};
        vecs[6] = '{8'h80, 8'h02, 16'h0100, 5};
        vecs[7] = '{8'hFF, 8'h01, 16'h00FF, 5};
        exp_m = '{4'h1, 4'h2, 4'h1, 4'h2};
        exp_q = '{4'h3, 4'h3, 4'h4, 4'h4};

        rst = 1'b1;
        v8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b0;
        v12 = 1'b0; a12 = '0; b12 = '0; or12 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset8", {14'h0, prod8, ov8, busy8, rdy8, m8, qn8},
            {14'h0, 16'h0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0});
        chk("reset12", {prod12, ov12, busy12, rdy12, m12, 1'b0},
            {24'h0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0});
        rst = 1'b0;

        foreach (vecs[i]) begin
            issue8(vecs[i].a, vecs[i].b, vecs[i].p);
            collect8(0, lat);
            chk($sformatf("lat_%0d", i), lat, vecs[i].lat);
        end

        // Nibble sequence presented to the shared multiplier
        @(negedge clk);
        v8 = 1'b1; a8 = 8'h21; b8 = 8'h43;
        @(posedge clk);
        sb8.push_back(16'h08A3);
        @(negedge clk);
        v8 = 1'b0;
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("nib_%0d", s), {24'h0, m8, qn8}, {24'h0, exp_m[s], exp_q[s]});
            if (s < 3) @(negedge clk);
        end
        collect8(0, lat);

        // Consumer stall: result and handshake state must hold
        issue8(8'h12, 8'h34, 16'h03A8);
        n = 0;
        while (!ov8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("stall_%0d", c), {13'h0, prod8, ov8, rdy8, busy8},
                {13'h0, 16'h03A8, 1'b1, 1'b0, 1'b1});
            @(negedge clk);
        end
        collect8(0, lat);

        // Reset during CALC step 2 aborts the operation
        @(negedge clk);
        v8 = 1'b1; a8 = 8'h55; b8 = 8'h66;
        @(posedge clk);
        @(negedge clk);
        v8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort", {21'h0, ov8, rdy8, busy8, m8, qn8},
            {21'h0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0});
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            if (ov8) n++;
            @(negedge clk);
        end
        chk("abort_no_result", n, 0);
        issue8(8'h0A, 8'h0B, 16'h006E);
        collect8(0, lat);

        // in_valid held through DONE must not latch the new pair early
        issue8(8'h11, 8'h11, 16'h0121);
        n = 0;
        while (!ov8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        v8 = 1'b1; a8 = 8'h03; b8 = 8'h05;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("done_hold_%0d", c), {14'h0, prod8, ov8, rdy8},
                {14'h0, 16'h0121, 1'b1, 1'b0});
        end
        or8 = 1'b1;
        if (sb8.size() != 0) void'(sb8.pop_front());
        @(posedge clk);
        @(negedge clk);
        or8 = 1'b0;
        chk("reidle", {30'h0, rdy8, ov8}, {30'h0, 1'b1, 1'b0});
        @(posedge clk);
        sb8.push_back(16'h000F);
        @(negedge clk);
        v8 = 1'b0;
        chk("reaccept", {30'h0, busy8, rdy8}, {30'h0, 1'b1, 1'b0});
        collect8(0, lat);

        for (int r = 0; r < 1000; r++) begin
            issue8(8'($urandom), 8'($urandom), 16'h0);
            void'(sb8.pop_back());
            sb8.push_back(16'(a8) * 16'(b8));
            collect8($urandom_range(0, 3), lat);
        end

        for (int r = 0; r < 1000; r++) begin
            issue12(12'($urandom), 12'($urandom));
            collect12($urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
